// File: rtl/audio_synth_pkg.sv
// audio_synth_pkg
// Shared types and defaults for the audio synthesis blocks.
//   seq_state_t    : note sequencer FSM state encoding
//   note_t         : one note table entry {freq, dur}
//   DEF_DIV_48KHZ  : sample-tick divider terminal count for a 12.5 MHz clock
//   NOTE_FREQ_W    : stored frequency word width
//   NOTE_DUR_W     : stored duration width (sample ticks)
package audio_synth_pkg;

  localparam int DEF_DIV_48KHZ = 259;
  localparam int NOTE_FREQ_W   = 16;
  localparam int NOTE_DUR_W    = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_PLAY = 2'd2,
    S_GAP  = 2'd3
  } seq_state_t;

  typedef struct packed {
    logic [NOTE_FREQ_W-1:0] freq;
    logic [NOTE_DUR_W-1:0]  dur;
  } note_t;

endpackage

// File: rtl/audio_tick_gen.sv
// audio_tick_gen
// Free-running divider producing a one-clock strobe every DIV+1 clocks.
// The counter starts at 0 out of reset and is never restarted, so every
// consumer sharing the strobe sees the same phase.
//   clk_i   : system clock
//   rstn_i  : asynchronous active-low reset
//   tick_o  : one-cycle strobe when the counter reaches DIV
module audio_tick_gen #(
  parameter int DIV = 259,
  localparam int CNT_W = (DIV > 0) ? $clog2(DIV + 1) : 1
) (
  input  logic clk_i,
  input  logic rstn_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (cnt_q == CNT_W'(DIV)) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign tick_o = (cnt_q == CNT_W'(DIV));

endmodule

// File: rtl/audio_note_sequencer.sv
// audio_note_sequencer
// Plays a programmable table of notes into a tone generator. Each entry is a
// frequency word and a duration in 48 kHz sample ticks; freq 0 is a rest.
// Notes may be followed by a silent gap, and the table plays once or loops.
//
// Control semantics: start_i and stop_i are single-cycle pulses sampled on
// the rising clock edge; stop_i has priority over everything, start_i is
// only honoured in IDLE. wr_en_i writes the table in any state. done_o is a
// one-cycle pulse on normal (non-looping) completion.
//
// Ports:
//   clk_i, rstn_i          : clock, asynchronous active-low reset
//   start_i, stop_i        : start / abort pulses
//   loop_i, last_i         : loop enable (sampled at end of last note), last index
//   wr_en_i, wr_addr_i,
//   wr_freq_i, wr_dur_i    : note table write port
//   freq_o, gate_o         : frequency word and gate to the generator
//   note_idx_o             : current table index
//   busy_o, done_o         : not-IDLE flag, completion pulse
//   sample_tick_o          : 48 kHz strobe
//   state_o                : FSM state, for debug and checkers
module audio_note_sequencer
  import audio_synth_pkg::*;
#(
  parameter int DIV_48KHZ = DEF_DIV_48KHZ,
  parameter int NOTES     = 16,
  parameter int FREQ_W    = NOTE_FREQ_W,
  parameter int DUR_W     = NOTE_DUR_W,
  parameter int GAP_TICKS = 2,
  localparam int IDX_W    = $clog2(NOTES)
) (
  input  logic              clk_i,
  input  logic              rstn_i,
  input  logic              start_i,
  input  logic              stop_i,
  input  logic              loop_i,
  input  logic [IDX_W-1:0]  last_i,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_addr_i,
  input  logic [FREQ_W-1:0] wr_freq_i,
  input  logic [DUR_W-1:0]  wr_dur_i,
  output logic [FREQ_W-1:0] freq_o,
  output logic              gate_o,
  output logic [IDX_W-1:0]  note_idx_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              sample_tick_o,
  output seq_state_t        state_o
);

  localparam int GAP_W = (GAP_TICKS > 0) ? $clog2(GAP_TICKS + 1) : 1;

  seq_state_t       state_q;
  logic [IDX_W-1:0] idx_q;
  logic [DUR_W-1:0] dur_cnt_q;
  logic [GAP_W-1:0] gap_cnt_q;
  logic             tick;

  // Note table: no reset, synchronous write. The read below is consumed only
  // by registers updated in LOAD, so a same-cycle write to the entry being
  // loaded delivers the old contents.
  note_t table_q [NOTES];
  note_t rd_note;

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      table_q[wr_addr_i] <= '{freq: NOTE_FREQ_W'(wr_freq_i),
                             dur:  NOTE_DUR_W'(wr_dur_i)};
    end
  end

  assign rd_note = table_q[idx_q];

  audio_tick_gen #(
    .DIV (DIV_48KHZ)
  ) u_tick_gen (
    .clk_i  (clk_i),
    .rstn_i (rstn_i),
    .tick_o (tick)
  );

  // Where to go once the current note (and its gap) is finished.
  seq_state_t       adv_state;
  logic [IDX_W-1:0] adv_idx;
  logic             adv_done;

  always_comb begin
    adv_state = S_LOAD;
    adv_idx   = idx_q;
    adv_done  = 1'b0;
    if (idx_q != last_i) begin
      adv_idx = idx_q + 1'b1;
    end else if (loop_i) begin
      adv_idx = '0;
    end else begin
      adv_state = S_IDLE;
      adv_done  = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      dur_cnt_q <= '0;
      gap_cnt_q <= '0;
      freq_o    <= '0;
      gate_o    <= 1'b0;
      done_o    <= 1'b0;
    end else begin
      done_o <= 1'b0;
      if (stop_i) begin
        state_q <= S_IDLE;
        gate_o  <= 1'b0;
        freq_o  <= '0;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (start_i) begin
              state_q <= S_LOAD;
              idx_q   <= '0;
            end
          end
          S_LOAD: begin
            freq_o    <= FREQ_W'(rd_note.freq);
            gate_o    <= (rd_note.freq != '0);
            // A zero duration still plays for one tick.
            dur_cnt_q <= (rd_note.dur == '0) ? DUR_W'(1) : DUR_W'(rd_note.dur);
            state_q   <= S_PLAY;
          end
          S_PLAY: begin
            if (tick) begin
              if (dur_cnt_q == DUR_W'(1)) begin
                // Gate drops on leaving PLAY whether we gap or reload.
                gate_o <= 1'b0;
                if (GAP_TICKS > 0) begin
                  state_q   <= S_GAP;
                  gap_cnt_q <= GAP_W'(GAP_TICKS);
                end else begin
                  state_q <= adv_state;
                  idx_q   <= adv_idx;
                  done_o  <= adv_done;
                end
              end else begin
                dur_cnt_q <= dur_cnt_q - 1'b1;
              end
            end
          end
          S_GAP: begin
            if (tick) begin
              if (gap_cnt_q == GAP_W'(1)) begin
                state_q <= adv_state;
                idx_q   <= adv_idx;
                done_o  <= adv_done;
              end else begin
                gap_cnt_q <= gap_cnt_q - 1'b1;
              end
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

  assign note_idx_o    = idx_q;
  assign busy_o        = (state_q != S_IDLE);
  assign sample_tick_o = tick;
  assign state_o       = state_q;

endmodule
